// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel path: default frame geometry,
// RGB565 field layout and the fetch FSM encoding.
package lcd_pkg;

    localparam int H_ACT_DEF = 320;
    localparam int V_ACT_DEF = 240;
    localparam int FRAME_PIX = H_ACT_DEF * V_ACT_DEF;

    localparam int ADDR_W = 17;

    // RGB565: [15:11] red, [10:5] green, [4:0] blue
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/lcd_sync_fifo.sv
// Synchronous show-ahead FIFO with flush; head reads as zero when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module lcd_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // At full, a same-cycle pop frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lcd_pix_feed.sv
// Frame-memory fetcher feeding the LCD timing stage through a pixel FIFO.
// Reads are issued only when the FIFO has room for every read in flight.
module lcd_pix_feed
    import lcd_pkg::*;
#(
    parameter int H_ACT      = H_ACT_DEF,
    parameter int V_ACT      = V_ACT_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    input  logic              pix_req,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_empty,
    output logic              underflow,
    output logic [1:0]        fsm_state
);

    // Handshakes: mem_rd has no backpressure and mem_data is valid exactly one
    // cycle later; pix_req pops the head only when pix_empty=0, else it is ignored.

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACT * V_ACT - 1);
    localparam logic [CW:0]       DEPTH_LIM = FIFO_DEPTH[CW:0];

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic           in_flight;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    committed;

    assign committed = {1'b0, fifo_count} + {{CW{1'b0}}, in_flight};
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd = (committed < DEPTH_LIM);
                if (frame_start)
                    state_nxt = ST_FETCH;
                else if (mem_rd && mem_addr == LAST_ADDR)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (frame_start) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // frame_start drops the read in flight so stale data never reaches the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            in_flight <= 1'b0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            mem_addr  <= '0;
            in_flight <= 1'b0;
            underflow <= 1'b0;
        end else begin
            in_flight <= mem_rd;
            if (mem_rd && mem_addr != LAST_ADDR) mem_addr <= mem_addr + 1'b1;
            if (pix_req && pix_empty) underflow <= 1'b1;
        end
    end

    lcd_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (in_flight),
        .push_data (mem_data),
        .pop       (pix_req),
        .head      (pix_data),
        .empty     (pix_empty),
        .count     (fifo_count)
    );

endmodule
